axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, AR address width.
REQ-002 Parameter DATA_WIDTH, default 64, R data width.
REQ-003 Port clock  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Ports s0_arvalid/s1_arvalid  input  1 each  read-address request; s0 = instruction cache, s1 = data cache.
REQ-006 Ports s0_araddr/s1_araddr  input  ADDR_WIDTH each  request address.
REQ-007 Ports s0_arlen/s1_arlen  input  8 each  burst length minus one.
REQ-008 Ports s0_arsize/s1_arsize  input  3 each  beat size.
REQ-009 Ports s0_arburst/s1_arburst  input  2 each  burst type.
REQ-010 Ports s0_arready/s1_arready  output  1 each  request accepted.
REQ-011 Ports s0_rvalid/s1_rvalid  output  1 each  forwarded read-data valid.
REQ-012 Ports s0_rdata/s1_rdata  output  DATA_WIDTH each  forwarded read data.
REQ-013 Ports s0_rlast/s1_rlast  output  1 each  forwarded last beat.
REQ-014 Ports s0_rready/s1_rready  input  1 each  requester accepts data.
REQ-015 Ports m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst  output  1/ADDR_WIDTH/8/3/2  shared AR channel.
REQ-016 Port m_axi_arready  input  1  memory accepts AR.
REQ-017 Ports m_axi_rvalid, m_axi_rdata, m_axi_rlast  input  1/DATA_WIDTH/1  shared R channel.
REQ-018 Port m_axi_rready  output  1  shared R ready.
REQ-019 Port grant  output  2  one-hot owner of the shared port; bit0 = s0, bit1 = s1; 0 when idle.
REQ-020 Port protocol_error  output  1  sticky R-beat-count mismatch flag.

Function
REQ-021 FSM states: IDLE, ADDR, DATA.
REQ-022 In IDLE with any sX_arvalid high, arbiter SHALL select a winner combinationally, assert that requester's sX_arready in the same cycle, latch its araddr/arlen/arsize/arburst, and move to ADDR.
REQ-023 Arbitration SHALL be round-robin: if both request, the requester not granted last wins; last_grant resets to s1, so s0 wins the first tie.
REQ-024 If only one requester is active, it SHALL win regardless of last_grant.
REQ-025 Only the winner SHALL see sX_arready high, and only in the IDLE acceptance cycle.
REQ-026 In ADDR, m_axi_arvalid SHALL be 1 with the latched fields held stable until m_axi_arready; on handshake, go to DATA.
REQ-027 AR latency: sX_arvalid accepted in cycle N -> m_axi_arvalid high in cycle N+1.
REQ-028 In DATA, m_axi_rvalid/rdata/rlast SHALL be forwarded combinationally to the owner only, and m_axi_rready SHALL equal the owner's sX_rready.
REQ-029 The non-owner SHALL see sX_rvalid = 0; its rdata SHALL be 0.
REQ-030 grant SHALL be held one-hot through ADDR and DATA, and SHALL be 0 in IDLE.
REQ-031 A 9-bit beat counter SHALL count R handshakes (m_axi_rvalid & m_axi_rready) in DATA; it SHALL clear on entry to DATA.
REQ-032 On the handshake beat with m_axi_rlast = 1, the FSM SHALL return to IDLE and update last_grant; the next grant is possible in the following cycle.
REQ-033 protocol_error SHALL set if rlast arrives with count != latched arlen, or if count would exceed arlen without rlast; it is cleared only by reset.
REQ-034 An overrun beat (count > arlen, no rlast) SHALL still be forwarded; the FSM waits for rlast.
REQ-035 A request arriving in ADDR or DATA SHALL wait, with arready low, until IDLE.
REQ-036 In ADDR and DATA, all m_axi outputs other than those defined above SHALL be 0.

Reset
REQ-037 Asserting reset at any time, including mid-burst, SHALL immediately force IDLE, grant = 0, last_grant = s1, counter = 0, protocol_error = 0, and every output to 0.
REQ-038 After reset deasserts, the first acceptance SHALL occur no earlier than the first rising edge.

Structure
REQ-039 The state enum and the grant encoding SHALL live in a shared package, axi_pkg, together with the AXI burst constants (INCR = 2'b01, WRAP = 2'b10) and the arsize constant for 8-byte beats (3'd3).
REQ-040 The round-robin selection SHALL be one sub-module, rr_arbiter2: two requests in, one-hot grant out, combinational logic using last_grant as an input.

Verification
REQ-041 Single s0 request, araddr = 0x1000, arlen = 7, arready on the first cycle, 8 beats -> grant = 01, m_axi_araddr = 0x1000 in cycle N+1, 8 beats on s0, back to IDLE, protocol_error = 0.
REQ-042 s0 and s1 request in the same cycle after reset -> s0 is served first; s1 is then served with arready one cycle after s0's rlast beat.
REQ-043 m_axi_arready is withheld for 5 cycles -> m_axi_arvalid and araddr stay stable for all 5 cycles, and sX_arready is not reasserted.
REQ-044 s1 deasserts s1_rready for 3 cycles mid-burst -> m_axi_rready = 0 for those cycles, and no beat is lost or duplicated.
REQ-045 arlen = 3 but rlast arrives on beat 6 -> protocol_error = 1 at the 5th beat, and the FSM returns to IDLE after beat 6.
REQ-046 reset is asserted during beat 3 of 8 -> all outputs are 0 asynchronously; a new s1 request is granted normally after release.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI read-port arbiter: FSM states,
// one-hot grant encodings and the AXI burst/size values.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_S0   = 2'b01;
    localparam logic [1:0] GRANT_S1   = 2'b10;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    localparam logic [2:0] ARSIZE_8B  = 3'd3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: a tie goes to whichever requester was not
// granted last; a lone requester always wins.
module rr_arbiter2
    import axi_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = GRANT_NONE;
        if (req_i == 2'b11) begin
            grant_o = (last_grant_i == GRANT_S0) ? GRANT_S1 : GRANT_S0;
        end else begin
            grant_o = req_i;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read port between the instruction cache (s0) and the data
// cache (s1); one outstanding burst at a time, owner chosen round-robin.
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  s0_arvalid,
    input  logic [ADDR_WIDTH-1:0] s0_araddr,
    input  logic [7:0]            s0_arlen,
    input  logic [2:0]            s0_arsize,
    input  logic [1:0]            s0_arburst,
    output logic                  s0_arready,
    output logic                  s0_rvalid,
    output logic [DATA_WIDTH-1:0] s0_rdata,
    output logic                  s0_rlast,
    input  logic                  s0_rready,

    input  logic                  s1_arvalid,
    input  logic [ADDR_WIDTH-1:0] s1_araddr,
    input  logic [7:0]            s1_arlen,
    input  logic [2:0]            s1_arsize,
    input  logic [1:0]            s1_arburst,
    output logic                  s1_arready,
    output logic                  s1_rvalid,
    output logic [DATA_WIDTH-1:0] s1_rdata,
    output logic                  s1_rlast,
    input  logic                  s1_rready,

    output logic                  m_axi_arvalid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    input  logic                  m_axi_arready,
    input  logic                  m_axi_rvalid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic                  m_axi_rlast,
    output logic                  m_axi_rready,

    output logic [1:0]            grant,
    output logic                  protocol_error
);

    state_e                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic [1:0]            last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;

    logic [1:0]            req;
    logic [1:0]            rr_grant;
    logic                  in_addr, in_data, accept, beat;
    logic [1:0]            own, s_rready, s_arready, s_rvalid, s_rlast;
    logic [DATA_WIDTH-1:0] s_rdata [2];

    assign req = {s1_arvalid, s0_arvalid};

    rr_arbiter2 u_rr (
        .req_i        (req),
        .last_grant_i (last_grant_q),
        .grant_o      (rr_grant)
    );

    assign in_addr  = (state_q == ADDR);
    assign in_data  = (state_q == DATA);
    // Gated by reset so no request is acknowledged while reset is held.
    assign accept   = (state_q == IDLE) && reset && (|req);
    assign s_rready = {s1_rready, s0_rready};
    assign m_axi_rready = in_data & (|(grant_q & s_rready));
    assign beat     = in_data & m_axi_rvalid & m_axi_rready;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        burst_d      = burst_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = ADDR;
                    grant_d = rr_grant;
                    addr_d  = rr_grant[1] ? s1_araddr  : s0_araddr;
                    len_d   = rr_grant[1] ? s1_arlen   : s0_arlen;
                    size_d  = rr_grant[1] ? s1_arsize  : s0_arsize;
                    burst_d = rr_grant[1] ? s1_arburst : s0_arburst;
                end
            end
            ADDR: begin
                if (m_axi_arready) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (beat) begin
                    // Saturate so a long overrun cannot wrap back into range.
                    if (cnt_q != '1) cnt_d = cnt_q + 9'd1;
                    if (m_axi_rlast) begin
                        if (cnt_q != {1'b0, len_q}) err_d = 1'b1;
                        state_d      = IDLE;
                        grant_d      = GRANT_NONE;
                        last_grant_d = grant_q;
                    end else if (cnt_q > {1'b0, len_q}) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_NONE;
            last_grant_q <= GRANT_S1;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slave
        assign own[gi]       = in_data & grant_q[gi];
        assign s_arready[gi] = accept & rr_grant[gi];
        assign s_rvalid[gi]  = own[gi] & m_axi_rvalid;
        assign s_rlast[gi]   = own[gi] & m_axi_rlast;
        assign s_rdata[gi]   = own[gi] ? m_axi_rdata : '0;
    end

    assign s0_arready = s_arready[0];
    assign s0_rvalid  = s_rvalid[0];
    assign s0_rlast   = s_rlast[0];
    assign s0_rdata   = s_rdata[0];
    assign s1_arready = s_arready[1];
    assign s1_rvalid  = s_rvalid[1];
    assign s1_rlast   = s_rlast[1];
    assign s1_rdata   = s_rdata[1];

    assign m_axi_arvalid  = in_addr;
    assign m_axi_araddr   = in_addr ? addr_q  : '0;
    assign m_axi_arlen    = in_addr ? len_q   : '0;
    assign m_axi_arsize   = in_addr ? size_q  : '0;
    assign m_axi_arburst  = in_addr ? burst_q : '0;

    assign grant          = grant_q;
    assign protocol_error = err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: arbitration table plus hand-written bursts for
// back-to-back service, AR stalls, R back-pressure, overrun and async reset.
module tb_axi_read_arbiter;
    import axi_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        s0_arvalid = 0, s1_arvalid = 0;
    logic [63:0] s0_araddr = 0, s1_araddr = 0;
    logic [7:0]  s0_arlen = 0, s1_arlen = 0;
    logic [2:0]  s0_arsize = 0, s1_arsize = 0;
    logic [1:0]  s0_arburst = 0, s1_arburst = 0;
    logic        s0_arready, s1_arready;
    logic        s0_rvalid, s1_rvalid, s0_rlast, s1_rlast;
    logic [63:0] s0_rdata, s1_rdata;
    logic        s0_rready = 0, s1_rready = 0;
    logic        m_axi_arvalid;
    logic [63:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arready = 0;
    logic        m_axi_rvalid = 0;
    logic [63:0] m_axi_rdata = 0;
    logic        m_axi_rlast = 0;
    logic        m_axi_rready;
    logic [1:0]  grant;
    logic        protocol_error;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q [$];

    always #5 clock = ~clock;

    axi_read_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clock(clock), .reset(reset),
        .s0_arvalid(s0_arvalid), .s0_araddr(s0_araddr), .s0_arlen(s0_arlen),
        .s0_arsize(s0_arsize), .s0_arburst(s0_arburst), .s0_arready(s0_arready),
        .s0_rvalid(s0_rvalid), .s0_rdata(s0_rdata), .s0_rlast(s0_rlast), .s0_rready(s0_rready),
        .s1_arvalid(s1_arvalid), .s1_araddr(s1_araddr), .s1_arlen(s1_arlen),
        .s1_arsize(s1_arsize), .s1_arburst(s1_arburst), .s1_arready(s1_arready),
        .s1_rvalid(s1_rvalid), .s1_rdata(s1_rdata), .s1_rlast(s1_rlast), .s1_rready(s1_rready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast),
        .m_axi_rready(m_axi_rready),
        .grant(grant), .protocol_error(protocol_error)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic owner_rvalid(input int o);
        return (o == 0) ? s0_rvalid : s1_rvalid;
    endfunction

    function automatic logic owner_rlast(input int o);
        return (o == 0) ? s0_rlast : s1_rlast;
    endfunction

    function automatic logic [63:0] owner_rdata(input int o);
        return (o == 0) ? s0_rdata : s1_rdata;
    endfunction

    task automatic set_rready(input int o, input logic v);
        if (o == 0) s0_rready = v;
        else        s1_rready = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_arready"}, {s1_arready, s0_arready}, 0);
        check({tag, "_m_ar"}, {m_axi_arvalid, m_axi_arlen, m_axi_arsize, m_axi_arburst}, 0);
        check({tag, "_m_araddr"}, m_axi_araddr, 0);
        check({tag, "_rctl"}, {m_axi_rready, s0_rvalid, s1_rvalid, s0_rlast, s1_rlast}, 0);
        check({tag, "_rdata"}, s0_rdata | s1_rdata, 0);
        check({tag, "_perr"}, protocol_error, 0);
    endtask

    // Present a request in IDLE and confirm the winner's one-cycle arready.
    task automatic accept(input logic v0, input logic v1, input logic [63:0] a0,
                          input logic [63:0] a1, input logic [7:0] len,
                          input int owner, input bit keep_loser);
        @(negedge clock);
        s0_arvalid = v0; s1_arvalid = v1;
        s0_araddr = a0;  s1_araddr = a1;
        s0_arlen = len;  s1_arlen = len;
        s0_arsize = ARSIZE_8B; s1_arsize = ARSIZE_8B;
        s0_arburst = BURST_INCR; s1_arburst = BURST_WRAP;
        #1;
        check("arready_s0", s0_arready, owner == 0);
        check("arready_s1", s1_arready, owner == 1);
        check("grant_idle", grant, 0);
        @(posedge clock);
        #1;
        if (owner == 0 || !keep_loser) s0_arvalid = 0;
        if (owner == 1 || !keep_loser) s1_arvalid = 0;
        $display("txn accept owner=s%0d len=%0d", owner, len);
    endtask

    task automatic addr_phase(input int waits, input int owner, input logic [63:0] addr,
                              input logic [7:0] len);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clock);
            m_axi_arready = (i == waits);
            #1;
            check("m_arvalid", m_axi_arvalid, 1);
            check("m_araddr", m_axi_araddr, addr);
            check("m_arlen", m_axi_arlen, len);
            check("m_arsize", m_axi_arsize, ARSIZE_8B);
            check("m_arburst", m_axi_arburst, owner == 0 ? BURST_INCR : BURST_WRAP);
            check("grant_addr", grant, owner == 0 ? GRANT_S0 : GRANT_S1);
            check("arready_addr", {s1_arready, s0_arready}, 0);
        end
        @(posedge clock);
        #1 m_axi_arready = 0;
    endtask

    task automatic data_phase(input int owner, input int nbeats, input int stall_at,
                              input int stall_len, input int err_beat);
        logic [63:0] d;
        int got;
        got = 0;
        for (int b = 0; b < nbeats; b++) begin
            d = {$urandom, $urandom};
            for (int s = 0; s < ((b == stall_at) ? stall_len : 0); s++) begin
                @(negedge clock);
                m_axi_rvalid = 1; m_axi_rdata = d; m_axi_rlast = (b == nbeats - 1);
                set_rready(owner, 0);
                #1;
                check("stall_m_rready", m_axi_rready, 0);
                check("stall_fwd_rvalid", owner_rvalid(owner), 1);
                @(posedge clock);
            end
            @(negedge clock);
            m_axi_rvalid = 1; m_axi_rdata = d; m_axi_rlast = (b == nbeats - 1);
            set_rready(owner, 1);
            exp_q.push_back(d);
            #1;
            check("m_rready", m_axi_rready, 1);
            check("grant_data", grant, owner == 0 ? GRANT_S0 : GRANT_S1);
            check("other_rvalid", owner_rvalid(1 - owner), 0);
            check("other_rdata", owner_rdata(1 - owner), 0);
            check("arready_data", {s1_arready, s0_arready}, 0);
            if (owner_rvalid(owner)) begin
                got++;
                if (exp_q.size() == 0) check("q_underflow", 1, 0);
                else check("rdata", owner_rdata(owner), exp_q.pop_front());
                check("rlast", owner_rlast(owner), b == nbeats - 1);
            end
            @(posedge clock);
            #1 check("perr", protocol_error, (err_beat != 0) && (b + 1 >= err_beat));
        end
        @(negedge clock);
        m_axi_rvalid = 0; m_axi_rlast = 0;
        set_rready(0, 0); set_rready(1, 0);
        check("beats", got, nbeats);
        check("q_empty", exp_q.size(), 0);
        check("grant_end", grant, 0);
        $display("txn burst done owner=s%0d beats=%0d", owner, got);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 0;
        #1 check_all_zero("rst");
        @(negedge clock);
        reset = 1;
    endtask

    typedef struct {
        logic       v0;
        logic       v1;
        logic [7:0] len;
        int         owner;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 8'd7, 0};
        tbl[1] = '{1'b1, 1'b1, 8'd0, 1};
        tbl[2] = '{1'b1, 1'b1, 8'd2, 0};
        tbl[3] = '{1'b0, 1'b1, 8'd1, 1};
        tbl[4] = '{1'b0, 1'b1, 8'd3, 1};
        tbl[5] = '{1'b1, 1'b1, 8'd0, 0};
        tbl[6] = '{1'b1, 1'b0, 8'd4, 0};
        tbl[7] = '{1'b1, 1'b1, 8'd1, 1};

        // Reset state, with a request pending that must not be acknowledged.
        s0_arvalid = 1;
        repeat (2) @(negedge clock);
        #1 check_all_zero("init");
        s0_arvalid = 0;
        @(negedge clock);
        reset = 1;

        for (int i = 0; i < 8; i++) begin
            logic [63:0] a0, a1;
            a0 = 64'h1000 + 64'(i) * 64'h100;
            a1 = 64'h8000 + 64'(i) * 64'h100;
            accept(tbl[i].v0, tbl[i].v1, a0, a1, tbl[i].len, tbl[i].owner, 1'b0);
            addr_phase(0, tbl[i].owner, tbl[i].owner == 0 ? a0 : a1, tbl[i].len);
            data_phase(tbl[i].owner, int'(tbl[i].len) + 1, -1, 0, 0);
        end

        // Tie straight after reset: s0 first, s1 accepted the cycle after rlast.
        do_reset();
        accept(1, 1, 64'h2000, 64'h3000, 8'd3, 0, 1'b1);
        addr_phase(0, 0, 64'h2000, 8'd3);
        data_phase(0, 4, -1, 0, 0);
        #1 check("s1_next_arready", s1_arready, 1);
        check("s0_next_arready", s0_arready, 0);
        @(posedge clock);
        #1 s1_arvalid = 0;
        addr_phase(0, 1, 64'h3000, 8'd3);
        data_phase(1, 4, -1, 0, 0);

        // AR withheld for 5 cycles while both caches keep requesting.
        accept(1, 0, 64'h4000, 64'h0, 8'd1, 0, 1'b0);
        s0_arvalid = 1; s1_arvalid = 1;
        addr_phase(5, 0, 64'h4000, 8'd1);
        s0_arvalid = 0; s1_arvalid = 0;
        data_phase(0, 2, -1, 0, 0);

        // s1 back-pressure for 3 cycles mid-burst.
        accept(0, 1, 64'h0, 64'h5000, 8'd5, 1, 1'b0);
        addr_phase(0, 1, 64'h5000, 8'd5);
        data_phase(1, 6, 2, 3, 0);

        // arlen=3 but rlast only on beat 6: flag raised by beat 5.
        accept(1, 0, 64'h6000, 64'h0, 8'd3, 0, 1'b0);
        addr_phase(0, 0, 64'h6000, 8'd3);
        data_phase(0, 6, -1, 0, 5);

        // Reset during beat 3 of 8, then a fresh s1 request.
        accept(1, 0, 64'h7000, 64'h0, 8'd7, 0, 1'b0);
        addr_phase(0, 0, 64'h7000, 8'd7);
        for (int b = 0; b < 2; b++) begin
            @(negedge clock);
            m_axi_rvalid = 1; m_axi_rdata = 64'(b) + 64'h77; s0_rready = 1;
            @(posedge clock);
        end
        @(negedge clock);
        m_axi_rdata = 64'hABCD; s1_arvalid = 1; s1_araddr = 64'h9000; s1_arlen = 8'd2;
        #1 check("pre_rst_fwd", s0_rdata, 64'hABCD);
        #1 reset = 0;
        #1 check_all_zero("async_rst");
        m_axi_rvalid = 0; s0_rready = 0;
        @(negedge clock);
        reset = 1;
        #1 check("post_rst_arready", s1_arready, 1);
        @(posedge clock);
        #1 s1_arvalid = 0;
        $display("txn accept owner=s1 after reset");
        addr_phase(0, 1, 64'h9000, 8'd2);
        data_phase(1, 3, -1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
